// File: rtl/video_pkg.sv
// video_pkg: shared video types, output bundle and RGB332 expansion helper.
package video_pkg;
    typedef enum logic [1:0] {MODE_SOLID, MODE_CHECK, MODE_BARS, MODE_GRAD} mode_e;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        hblank;
        logic        vblank;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
    } vid_out_t;

    function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v counters with combinational sync and blank decode of the current position.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    output logic [11:0] h,
    output logic [11:0] v,
    output logic        hblank,
    output logic        vblank,
    output logic        hs,
    output logic        vs,
    output logic        frame_wrap
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [11:0] h_q, h_d, v_q, v_d;
    logic        h_last, v_last;

    always_comb begin
        h_last = h_q == 12'(H_TOTAL - 1);
        v_last = v_q == 12'(V_TOTAL - 1);
        h_d    = h_q;
        v_d    = v_q;
        if (ce_pix) begin
            h_d = h_last ? 12'd0 : h_q + 12'd1;
            v_d = !h_last ? v_q : v_last ? 12'd0 : v_q + 12'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h          = h_q;
    assign v          = v_q;
    assign frame_wrap = h_last && v_last;
    assign hblank     = h_q >= 12'(H_ACTIVE);
    assign vblank     = v_q >= 12'(V_ACTIVE);
    assign hs = (h_q >= 12'(H_ACTIVE + H_FP) && h_q < 12'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : !HS_POL;
    assign vs = (v_q >= 12'(V_ACTIVE + V_FP) && v_q < 12'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : !VS_POL;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: programmable video timing with four test patterns and one registered output stage.
module vga_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CHECK_LOG2 = 5,
    parameter int BAR_LOG2   = 6
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [1:0]  mode,
    input  logic [7:0]  color,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        hblank,
    output logic        vblank,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);
    logic [11:0] h, v;
    logic        hb, vb, hs_c, vs_c, frame_wrap;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
        .h(h), .v(v), .hblank(hb), .vblank(vb), .hs(hs_c), .vs(vs_c),
        .frame_wrap(frame_wrap)
    );

    mode_e       mode_q, mode_d;
    logic [7:0]  color_q, color_d, frame_q, frame_d, gray;
    logic [2:0]  bar;
    logic [23:0] pix;
    vid_out_t    out_q, out_d;

    always_comb begin
        bar  = 3'(h >> BAR_LOG2);
        gray = h[7:0] + frame_q;
        pix  = mode_q == MODE_SOLID ? rgb332_expand(color_q) :
               mode_q == MODE_CHECK ? ((h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? rgb332_expand(color_q) : 24'd0) :
               mode_q == MODE_BARS  ? rgb332_expand({{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}}) :
                                      {3{gray}};
        // Pattern settings only move at frame wrap so a frame never mixes two modes.
        mode_d   = (ce_pix && frame_wrap) ? mode_e'(mode) : mode_q;
        color_d  = (ce_pix && frame_wrap) ? color : color_q;
        frame_d  = (ce_pix && frame_wrap) ? frame_q + 8'd1 : frame_q;
        out_d    = out_q;
        out_d.fs = 1'b0;
        if (ce_pix)
            out_d = '{rgb: (hb || vb) ? 24'd0 : pix, hs: hs_c, vs: vs_c, hblank: hb, vblank: vb,
                      fs: h == 12'd0 && v == 12'd0, x: h, y: v};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_SOLID;
            color_q <= 8'hFF;
            frame_q <= '0;
            out_q   <= '{rgb: 24'd0, hs: !HS_POL, vs: !VS_POL, hblank: 1'b1, vblank: 1'b1,
                         fs: 1'b0, x: 12'd0, y: 12'd0};
        end else begin
            mode_q  <= mode_d;
            color_q <= color_d;
            frame_q <= frame_d;
            out_q   <= out_d;
        end
    end

    assign {r, g, b}   = out_q.rgb;
    assign hs          = out_q.hs;
    assign vs          = out_q.vs;
    assign hblank      = out_q.hblank;
    assign vblank      = out_q.vblank;
    assign de          = !(out_q.hblank || out_q.vblank);
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign frame_start = out_q.fs;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed and randomized checks against a pixel-index reference model.
module tb_vga_pattern_gen;
    logic        clk_sys = 1'b0, reset = 1'b0, ce_pix = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  color = 8'd0;
    logic [7:0]  r, g, b;
    logic        hs, vs, de, hblank, vblank, frame_start;
    logic [11:0] x, y;

    int passed = 0, total = 0;
    int n;
    logic [1:0]  m_mode;
    logic [7:0]  m_color, e_r, e_g, e_b;
    logic        e_hs, e_vs, e_de, e_hb, e_vb, e_fs;
    logic [11:0] e_x, e_y;

    vga_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(2), .BAR_LOG2(1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .mode(mode), .color(color),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de), .hblank(hblank), .vblank(vblank),
        .x(x), .y(y), .frame_start(frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [23:0] expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        n = 0; m_mode = 2'd0; m_color = 8'hFF;
        {e_r, e_g, e_b} = 24'd0;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_fs = 1'b0;
        e_x = 12'd0; e_y = 12'd0;
    endtask

    // Output for the n-th emitted pixel, derived only from its position in the raster.
    task automatic model_pixel();
        int h, v, fc;
        logic [2:0]  i;
        logic [23:0] rgb;
        h = n % 24; v = (n / 24) % 12; fc = (n / 288) % 256;
        i = 3'((h / 2) % 8);
        e_x = 12'(h); e_y = 12'(v);
        e_hb = h >= 16; e_vb = v >= 8; e_de = !(e_hb || e_vb);
        e_hs = !(h >= 18 && h < 22); e_vs = !(v >= 9 && v < 11);
        e_fs = h == 0 && v == 0;
        if (!e_de) rgb = 24'd0;
        else if (m_mode == 2'd0) rgb = expand(m_color);
        else if (m_mode == 2'd1) rgb = ((h / 4) % 2 != (v / 4) % 2) ? expand(m_color) : 24'd0;
        else if (m_mode == 2'd2) rgb = expand({{3{i[2]}}, {3{i[1]}}, {2{i[0]}}});
        else rgb = {3{8'((h + fc) % 256)}};
        {e_r, e_g, e_b} = rgb;
        if (h == 23 && v == 11) begin m_mode = mode; m_color = color; end
        n++;
    endtask

    task automatic check_all();
        chk("r", 32'(r), 32'(e_r)); chk("g", 32'(g), 32'(e_g)); chk("b", 32'(b), 32'(e_b));
        chk("hs", 32'(hs), 32'(e_hs)); chk("vs", 32'(vs), 32'(e_vs)); chk("de", 32'(de), 32'(e_de));
        chk("hblank", 32'(hblank), 32'(e_hb)); chk("vblank", 32'(vblank), 32'(e_vb));
        chk("x", 32'(x), 32'(e_x)); chk("y", 32'(y), 32'(e_y));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic step(input logic ce);
        ce_pix = ce;
        @(posedge clk_sys);
        if (ce) model_pixel(); else e_fs = 1'b0;
        #1 check_all();
    endtask

    task automatic run_to(input int hh, input int vv);
        int k = 0;
        do begin step(1'b1); k++; end while (!(e_x == 12'(hh) && e_y == 12'(vv)) && k < 400);
        chk("run_to_bound", 32'(k < 400), 32'd1);
    endtask

    initial begin
        int de_cnt, hs_lo, vs_lo, hs_fall, f, k;
        logic hs_prev;
        logic [7:0] solid;
        reset_model();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 check_all();
        reset = 1'b0;
        repeat (3) step(1'b0);

        // Frame 0: first ce, then sync/de period counts.
        de_cnt = 0; hs_lo = 0; vs_lo = 0; hs_fall = 0; hs_prev = 1'b1;
        for (int i = 0; i < 288; i++) begin
            step(1'b1);
            if (i == 0) begin
                chk("first_fs", 32'(frame_start), 32'd1);
                chk("first_xy", 32'({x, y}), 32'd0);
                chk("first_de", 32'(de), 32'd1);
                mode = 2'd1; color = 8'hE0;
            end
            de_cnt += int'(de); hs_lo += int'(!hs); vs_lo += int'(!vs);
            hs_fall += int'(hs_prev && !hs); hs_prev = hs;
        end
        chk("de_per_frame", 32'(de_cnt), 32'd128);
        chk("hs_low_per_frame", 32'(hs_lo), 32'd48);
        chk("hs_pulses_per_frame", 32'(hs_fall), 32'd12);
        chk("vs_low_per_frame", 32'(vs_lo), 32'd48);

        // Frames 1..3: checkerboard, solid with mid-frame mode change, then bars.
        for (int i = 0; i < 3 * 288; i++) begin
            step(1'b1);
            f = (n - 1) / 288;
            if (f == 1 && e_x == 12'd4 && e_y == 12'd0) chk("chk_4_0", 32'({r, g, b}), 32'hFF0000);
            if (f == 1 && e_x == 12'd0 && e_y == 12'd0) chk("chk_0_0", 32'({r, g, b}), 32'd0);
            if (f == 1 && e_x == 12'd4 && e_y == 12'd4) chk("chk_4_4", 32'({r, g, b}), 32'd0);
            if (f == 1 && e_x == 12'd23 && e_y == 12'd10) begin mode = 2'd0; color = 8'($urandom); solid = color; end
            if (f == 2 && e_x == 12'd0 && e_y == 12'd3) mode = 2'd2;
            if (f == 2 && e_x == 12'd2 && e_y == 12'd7) chk("solid_holds", 32'({r, g, b}), 32'(expand(solid)));
            if (f == 3 && e_x == 12'd2 && e_y == 12'd0) begin
                chk("bar1_fs_seen", 32'(n), 32'(3 * 288 + 3));
                chk("bar1", 32'({r, g, b}), 32'h0000FF);
            end
        end

        // Randomized ce and pattern inputs; gradient selected before the last wrap.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 15) == 0) begin mode = 2'($urandom); color = 8'($urandom); end
            step(1'($urandom_range(0, 1)));
        end
        mode = 2'd3;
        run_to(0, 0);

        run_to(5, 0);
        chk("grad_a", 32'(r), 32'(8'(5 + (n - 1) / 288)));
        run_to(5, 0);
        chk("grad_b", 32'(r), 32'(8'(5 + (n - 1) / 288)));
        k = 0;
        while (((n - 1) / 288) % 256 != 0 && k < 300) begin run_to(5, 0); k++; end
        chk("grad_wrap_reached", 32'(k < 300), 32'd1);
        chk("grad_wrap", 32'({r, g, b}), 32'h050505);

        // Toggling ce, then async reset in the middle of line 5.
        k = 0;
        while (!(e_y == 12'd5 && e_x == 12'd3) && k < 2000) begin step(1'b1); step(1'b0); k++; end
        chk("line5_reached", 32'(k < 2000), 32'd1);
        step(1'b0);
        chk("freeze_x", 32'(x), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_xy", 32'({x, y}), 32'd0);
        reset_model();
        check_all();
        @(negedge clk_sys) reset = 1'b0;
        #1 step(1'b1);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

- Parametrised video timing and test-pattern generator; successor to the fixed-mode checkerboard `vga` block used by the Lesson cores.
- Generates programmable H/V timing with selectable sync polarity and pixel clock-enable.
- Produces four runtime-selectable patterns driven by an RGB332 foreground colour.
- Sits between `hps_io`/joystick logic and the emu video outputs (`VGA_*`, `CE_PIXEL`).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
- BAR_LOG2, 6, colour bar width = 2^BAR_LOG2 pixels

Ports (one clock; reset asynchronous, active-high):
- clk_sys  in  1  system/video clock
- reset  in  1  async active-high reset
- ce_pix  in  1  pixel enable; all state advances only when high
- mode  in  2  0 solid, 1 checkerboard, 2 colour bars, 3 scrolling gradient
- color  in  8  foreground RGB332 {R[2:0],G[2:0],B[1:0]}
- r, g, b  out  8 each  pixel colour
- hs, vs  out  1 each  syncs at the parameter polarity
- de  out  1  data enable = ~(hblank|vblank)
- hblank, vblank  out  1 each  blanking flags
- x, y  out  12 each  coordinates of the current output pixel
- frame_start  out  1  one-clk_sys pulse coincident with output pixel (0,0)

## Operation
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. h_cnt runs 0..H_TOTAL-1 and wraps; v_cnt increments on h wrap and wraps at V_TOTAL-1.
- Horizontal regions: active h<H_ACTIVE; FP; sync for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); BP. Vertical regions are analogous.
- RGB332 expansion: r={c[7:5],c[7:5],c[7:6]}, g={c[4:2],c[4:2],c[4:3]}, b={c[1:0]}×4.
- mode_q/color_q latch mode/color only at frame wrap (ce_pix with h=H_TOTAL-1, v=V_TOTAL-1). Mid-frame changes never tear.
- frame_cnt (8 bit) increments at frame wrap; 255 wraps to 0.
- Patterns (active region only):
  - 0: color_q.
  - 1: color_q if x[CHECK_LOG2]^y[CHECK_LOG2], else 0.
  - 2: i=(x>>BAR_LOG2)&7; RGB332 = {i[2]×3, i[1]×3, i[0]×2}.
  - 3: gray r=g=b=(x[7:0]+frame_cnt) mod 256.
- Outside active region r=g=b=0.

## Timing
- Reset values: h_cnt=v_cnt=0, frame_cnt=0, mode_q=0, color_q=8'hFF; r=g=b=0, de=0, hblank=vblank=1, hs=~HS_POL, vs=~VS_POL, x=y=0, frame_start=0.
- Latency: one registered stage. On a ce_pix cycle the outputs take the values decoded from the pre-increment counters.
- First ce_pix after reset outputs pixel (0,0) with de=1 and frame_start=1.
- ce_pix low: all outputs and counters hold; frame_start deasserts after one clk_sys.
- hs and vs change on the same ce edge as de, with no skew between outputs.
- Reset mid-line: everything returns to reset values immediately, asynchronously.

## Structure
- Package `video_pkg`: mode enum (MODE_SOLID, MODE_CHECK, MODE_BARS, MODE_GRAD) and function rgb332_expand.
- Sub-module `vga_timing`: counters, sync/blank decode, x/y.
- Top level holds mode/colour latch, frame_cnt, pattern mux and output register.

## Test plan
Bench parameters: H 16/2/4/2, V 8/1/2/1 (H_TOTAL=24, V_TOTAL=12), CHECK_LOG2=2, BAR_LOG2=1.
- Reset, then ce_pix=1 continuously:
  - outputs hold reset values until the first ce;
  - first ce gives frame_start=1, x=y=0, de=1.
- Line/frame period:
  - hs active for exactly 4 ce per line, period 24 ce;
  - vs active 2 lines, period 288 ce;
  - de high 16×8 pixels per frame.
- mode=1, color=8'hE0:
  - pixel (4,0) gives r=8'hFF, g=b=0;
  - pixel (0,0) gives 0;
  - pixel (4,4) gives 0.
- Mode change mid-frame: switch 0→2 at line 3. Output stays solid until the next frame_start; then x=2 gives bar 1 = RGB332 8'h03 (b=8'hFF).
- mode=3, two consecutive frames: pixel (5,0) gray 5, then 6. frame_cnt 255 wraps so the pixel shows 5.
- ce_pix toggling 1/0 plus async reset at line 5: outputs freeze on low ce, and reset forces hs=1, de=0, rgb=0 on the same cycle.
